// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared constants and FSM encoding for the streaming 2x2 max-pool engine
package maxpool_pkg;

   localparam int IN_DIM  = 24;
   localparam int DATA_W  = 8;
   localparam int OUT_DIM = IN_DIM / 2;
   localparam int RD_AW   = $clog2(IN_DIM * IN_DIM);
   localparam int WR_AW   = $clog2(OUT_DIM * OUT_DIM);
   localparam int CW      = $clog2(IN_DIM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

endpackage

// File: rtl/maxpool_smax2.sv
// rtl/maxpool_smax2.sv - combinational signed two-input maximum
module maxpool_smax2
   import maxpool_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// rtl/maxpool_stream_ctrl.sv - sequential 2x2 stride-2 signed max-pool, one pixel per cycle
module maxpool_stream_ctrl
   import maxpool_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   output logic              rd_en,
   output logic [RD_AW-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [WR_AW-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam int LAST_RD = IN_DIM * IN_DIM - 1;

   state_t              state;
   logic [CW-1:0]       row, col;
   logic [CW-1:0]       tag_row, tag_col;
   logic                tag_vld;
   logic [DATA_W-1:0]   pair;
   logic [DATA_W-1:0]   h_max, v_max;
   logic [DATA_W-1:0]   line_buf [OUT_DIM];
   logic [CW-2:0]       lb_idx;
   logic                rd_last;

   assign rd_en   = (state == READ) && !stall;
   assign rd_last = (rd_addr == RD_AW'(LAST_RD));
   assign lb_idx  = tag_col[CW-1:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         row     <= '0;
         col     <= '0;
         rd_addr <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= READ;
                  busy  <= 1'b1;
               end
            end
            READ: begin
               if (rd_en) begin
                  if (rd_last) begin
                     state   <= DRAIN;
                     rd_addr <= '0;
                     row     <= '0;
                     col     <= '0;
                  end else begin
                     rd_addr <= rd_addr + RD_AW'(1);
                     if (col == CW'(IN_DIM - 1)) begin
                        col <= '0;
                        row <= row + CW'(1);
                     end else begin
                        col <= col + CW'(1);
                     end
                  end
               end
            end
            // Last pixel arrived the cycle before; its write is on the bus once the pipe empties.
            DRAIN: begin
               if (!tag_vld) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= 1'b0;
         tag_row <= '0;
         tag_col <= '0;
         pair    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         tag_vld <= rd_en;
         if (rd_en) begin
            tag_row <= row;
            tag_col <= col;
         end
         wr_en <= 1'b0;
         if (tag_vld) begin
            if (!tag_col[0]) begin
               pair <= rd_data;
            end else if (tag_row[0]) begin
               wr_en   <= 1'b1;
               wr_data <= v_max;
               wr_addr <= WR_AW'(tag_row[CW-1:1]) * WR_AW'(OUT_DIM) + WR_AW'(tag_col[CW-1:1]);
            end
         end
      end
   end

   // Horizontal pair maxima of even rows wait here for the matching odd row.
   always_ff @(posedge clk) begin
      if (tag_vld && tag_col[0] && !tag_row[0])
         line_buf[lb_idx] <= h_max;
   end

   maxpool_smax2 #(.W(DATA_W)) u_hmax (
      .a (pair),
      .b (rd_data),
      .y (h_max)
   );

   maxpool_smax2 #(.W(DATA_W)) u_vmax (
      .a (line_buf[lb_idx]),
      .b (h_max),
      .y (v_max)
   );

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// tb/tb_maxpool_stream_ctrl.sv - self-checking bench for maxpool_stream_ctrl
module tb_maxpool_stream_ctrl;
   import maxpool_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stall = 1'b0;
   logic              rd_en;
   logic [RD_AW-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data = '0;
   logic              wr_en;
   logic [WR_AW-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;

   maxpool_stream_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stall   (stall),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   logic [7:0] fmem [IN_DIM*IN_DIM];
   always @(posedge clk) if (rd_en) rd_data <= fmem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   int start_cyc = 0;
   int rd_cnt, rd_addr_err, first_rd, done_cnt, done_rel, busy_first, busy_last, busy_cnt;
   int wr_addr_q[$];
   int wr_data_q[$];
   int wr_rel_q[$];

   always @(negedge clk) begin
      int rel;
      rel = cyc - start_cyc;
      if (rd_en) begin
         if (rd_cnt == 0) first_rd = rel;
         if (int'(rd_addr) != rd_cnt) rd_addr_err++;
         rd_cnt++;
      end
      if (wr_en) begin
         wr_addr_q.push_back(int'(wr_addr));
         wr_data_q.push_back(int'(wr_data));
         wr_rel_q.push_back(rel);
      end
      if (done) begin
         done_cnt++;
         done_rel = rel;
      end
      if (busy) begin
         if (busy_cnt == 0) busy_first = rel;
         busy_last = rel;
         busy_cnt++;
      end
   end

   task automatic clear_log();
      rd_cnt = 0; rd_addr_err = 0; first_rd = -1; done_cnt = 0; done_rel = -1;
      busy_first = -1; busy_last = -1; busy_cnt = 0;
      wr_addr_q.delete(); wr_data_q.delete(); wr_rel_q.delete();
   endtask

   // 0: no stall, 1: toggle every cycle, 2: random
   int stall_mode = 0;
   initial forever begin
      @(posedge clk); #1;
      case (stall_mode)
         1:       stall = ~stall;
         2:       stall = 1'($urandom_range(0, 1));
         default: stall = 1'b0;
      endcase
   end

   function automatic int pix(input int r, input int c);
      return int'($signed(fmem[r*IN_DIM + c]));
   endfunction

   // Must be called just after a negedge; returns in the cycle after done.
   task automatic run_frame(input string tag, input bit timing, input bit stray);
      int ex[OUT_DIM*OUT_DIM];
      int bad;
      int last_rel;
      for (int i = 0; i < OUT_DIM*OUT_DIM; i++) begin
         int r, c, m;
         r = 2 * (i / OUT_DIM);
         c = 2 * (i % OUT_DIM);
         m = pix(r, c);
         if (pix(r, c+1)   > m) m = pix(r, c+1);
         if (pix(r+1, c)   > m) m = pix(r+1, c);
         if (pix(r+1, c+1) > m) m = pix(r+1, c+1);
         ex[i] = m & 255;
      end
      clear_log();
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         int rel;
         rel = cyc - start_cyc;
         if (stray) start = (rel == 50 || rel == 578);
         if (done_cnt > 0 && rel >= done_rel + 1) break;
         @(negedge clk); #1;
      end
      start = 1'b0;
      chk({tag, " done_cnt"}, done_cnt, 1);
      chk({tag, " rd_cnt"}, rd_cnt, IN_DIM*IN_DIM);
      chk({tag, " rd_addr_err"}, rd_addr_err, 0);
      chk({tag, " wr_cnt"}, wr_addr_q.size(), OUT_DIM*OUT_DIM);
      bad = 0;
      for (int i = 0; i < wr_addr_q.size(); i++)
         if (i >= OUT_DIM*OUT_DIM || wr_addr_q[i] != i || wr_data_q[i] != ex[i]) bad++;
      chk({tag, " wr_bad"}, bad, 0);
      last_rel = (wr_rel_q.size() > 0) ? wr_rel_q[wr_rel_q.size()-1] : -1;
      chk({tag, " busy_contig"}, busy_cnt, busy_last - busy_first + 1);
      chk({tag, " busy_last"}, busy_last, last_rel);
      chk({tag, " done_after_wr"}, done_rel, last_rel + 1);
      if (timing) begin
         chk({tag, " first_rd"}, first_rd, 1);
         chk({tag, " first_wr"}, (wr_rel_q.size() > 0) ? wr_rel_q[0] : -1, 3 + IN_DIM + 1);
         chk({tag, " last_wr"}, last_rel, IN_DIM*IN_DIM + 2);
         chk({tag, " done_rel"}, done_rel, IN_DIM*IN_DIM + 3);
         chk({tag, " busy_first"}, busy_first, 1);
      end
   endtask

   task automatic fill_window();
      for (int i = 0; i < OUT_DIM*OUT_DIM; i++) begin
         int r, c;
         r = 2 * (i / OUT_DIM);
         c = 2 * (i % OUT_DIM);
         for (int k = 0; k < 4; k++)
            fmem[(r + k/2)*IN_DIM + c + k%2] = (k == i % 4) ? 8'(i & 127) : 8'h81;
      end
   endtask

   initial begin
      int n_wr_before, n_rd_before;
      clear_log();
      repeat (2) @(negedge clk);
      #1;
      chk("rst rd_en", rd_en, 0);
      chk("rst wr_en", wr_en, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst rd_addr", rd_addr, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      for (int j = 0; j < IN_DIM*IN_DIM; j++) begin
         int r, c;
         r = j / IN_DIM;
         c = j % IN_DIM;
         if (r % 2 == 0) fmem[j] = (c % 2 == 0) ? 8'h55 : 8'hA8;
         else            fmem[j] = (c % 2 == 0) ? 8'h75 : 8'h28;
      end
      run_frame("rowpat", 1'b1, 1'b1);
      chk("rowpat wr_data0", (wr_data_q.size() > 0) ? wr_data_q[0] : -1, 32'h75);

      for (int j = 0; j < IN_DIM*IN_DIM; j++) fmem[j] = 8'h80;
      run_frame("all_neg", 1'b1, 1'b0);

      for (int j = 0; j < IN_DIM*IN_DIM; j++) fmem[j] = 8'h7F;
      for (int i = 0; i < OUT_DIM*OUT_DIM; i++) begin
         int k;
         k = $urandom_range(0, 3);
         fmem[(2*(i/OUT_DIM) + k/2)*IN_DIM + 2*(i%OUT_DIM) + k%2] = 8'h80;
      end
      run_frame("signed", 1'b1, 1'b0);
      chk("signed wr_data_last", (wr_data_q.size() > 0) ? wr_data_q[wr_data_q.size()-1] : -1, 32'h7F);

      fill_window();
      run_frame("window", 1'b1, 1'b0);

      stall_mode = 1;
      run_frame("win_stall", 1'b0, 1'b0);

      stall_mode = 2;
      for (int j = 0; j < IN_DIM*IN_DIM; j++) fmem[j] = 8'($urandom);
      run_frame("random", 1'b0, 1'b0);
      stall_mode = 0;
      @(negedge clk); #1;

      clear_log();
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #1;
      start = 1'b0;
      while (cyc - start_cyc < 200) begin
         @(negedge clk); #1;
      end
      n_wr_before = wr_addr_q.size();
      rst_n = 1'b0;
      #1;
      chk("abort rd_en", rd_en, 0);
      chk("abort wr_en", wr_en, 0);
      chk("abort busy", busy, 0);
      chk("abort wr_data", wr_data, 0);
      chk("abort wr_addr", wr_addr, 0);
      repeat (4) @(negedge clk);
      #1;
      rst_n = 1'b1;
      n_rd_before = rd_cnt;
      repeat (20) @(negedge clk);
      #1;
      chk("abort no_wr", wr_addr_q.size(), n_wr_before);
      chk("abort no_rd", rd_cnt, n_rd_before);
      chk("abort idle", busy, 0);
      run_frame("post_rst", 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/maxpool_stream_ctrl.md
Name: maxpool_stream_ctrl

Overview:
- Sequential 2x2/stride-2 signed max-pool engine that replaces the fully combinational 24x24 to 12x12 pooling stage where LUT budget is tight.
- Reads the conv feature map one pixel per cycle, raster order, from a synchronous feature RAM.
- Keeps horizontal pair maxima in a half-width line buffer and writes the 12x12 pooled map to an output RAM.
- Sits between the conv-output buffer and the dense-layer input buffer; started by the top-level layer sequencer.

Parameters:
- IN_DIM, 24, input feature-map side (even, >= 2).
- DATA_W, 8, pixel width, two's-complement signed.
- OUT_DIM, IN_DIM/2, derived, output side; not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to pool one frame; sampled only in IDLE.
- stall  in  1  when high, no new read is issued this cycle.
- rd_en  out  1  feature RAM read strobe.
- rd_addr  out  clog2(IN_DIM*IN_DIM)  read address = row*IN_DIM + col.
- rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  pooled RAM write strobe.
- wr_addr  out  clog2(OUT_DIM*OUT_DIM)  write address = (row/2)*OUT_DIM + col/2.
- wr_data  out  DATA_W  pooled value.
- busy  out  1  high from first read through last write.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, counters 0. Line buffer contents are don't-care.
- FSM states:
  - IDLE: on start, go to READ.
  - READ: issue reads; after read 575 (IN_DIM^2-1) is issued, go to DRAIN.
  - DRAIN: wait until the valid pipe is empty and the final write has issued, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Read side:
  - In READ, rd_en = !stall. Address counter (row, col) advances only on an issued read; col wraps at IN_DIM-1 and increments row.
- Data pipe:
  - A 1-bit valid shift register plus registered row/col tags track each read. Only tagged data is processed, so stalls create bubbles and never drop or duplicate pixels.
- Even column: hold the pixel in a pair register.
- Odd column: h = smax(pair, pixel).
  - Even row: line_buf[col/2] <= h.
  - Odd row: v = smax(line_buf[col/2], h); wr_en=1, wr_data=v, wr_addr from the tags, all registered, one cycle after the pixel arrives.
- Comparison is signed; ties select either operand (identical values). There is no width growth.
- Timing with no stall (cycle 0 = start sampled):
  - rd_en high cycles 1..576, addresses 0..575.
  - First write at cycle 3+IN_DIM+1 (cycle 28).
  - Last write at cycle 578; done at cycle 579.
  - busy high cycles 1..578.
- Boundaries:
  - start outside IDLE is ignored.
  - start coincident with done is ignored; a new start is accepted from the following IDLE cycle.
  - stall during DRAIN/FIN has no effect.
  - rst_n asserted mid-frame aborts immediately with no further wr_en; partial output RAM contents are undefined.
  - wr_en is never asserted for even rows.
  - Exactly OUT_DIM^2 writes per frame, addresses strictly increasing 0..143.

Decomposition:
- Package maxpool_pkg: DATA_W, IN_DIM, OUT_DIM, address-width constants, FSM state encoding (IDLE, READ, DRAIN, FIN).
- Sub-module maxpool_smax2: combinational signed 2-input max, DATA_W wide, instantiated twice (horizontal and vertical).
- Line buffer is an inferred OUT_DIM x DATA_W register array inside the top module.

Test Plan:
- Row pattern: even rows repeat {0x55,0xA8}, odd rows repeat {0x75,0x28} -> all 144 writes wr_data=0x75, addresses 0..143, done at cycle 579.
- All pixels 0x80 (-128) -> every wr_data=0x80. Second frame, all 0x7F except one 0x80 per window -> every wr_data=0x7F (signed compare check).
- Window i: max i[6:0] at corner (i mod 4), other three pixels 0x81 -> wr_data=i[6:0] at wr_addr=i for all i.
- stall toggling every cycle -> exactly 576 rd_en pulses, results identical to the window-i test, one done pulse, busy continuous.
- start pulsed at cycles 50 and 578 -> ignored; start in cycle 580 -> second frame starts with rd_en at 581.
- rst_n low at cycle 200 -> all outputs 0 asynchronously, no wr_en until the next start, then a fresh complete 144-write frame.
